// File: rtl/i2s_rx_sequencer.sv
// i2s_rx_sequencer
//   Frames a pre-synchronised I2S serial stream into left/right sample pairs.
//   All logic runs on MCLK; bit-clock and word-select edges arrive as
//   one-MCLK strobes produced upstream.
//
// Parameters
//   DW    audio sample width in bits (2..SLOT-1)
//   SLOT  maximum BCLK periods in one channel slot
//
// Ports
//   MCLK       system clock (rising edge)
//   RST        asynchronous active-high reset
//   EN         receiver enable (level)
//   SDATA      serial data, already in the MCLK domain
//   BCLK_RISE  one-cycle strobe per bit-clock rising edge
//   LR_RISE    one-cycle strobe on LRCLK 0->1 (right slot starts)
//   LR_FALL    one-cycle strobe on LRCLK 1->0 (left slot starts)
//   READY      consumer accepts the held pair
//   ERR_CLR    clears SYNC_ERR / OVERRUN
//   L_DATA     held left sample, MSB-first assembled
//   R_DATA     held right sample
//   VALID      held pair not yet consumed
//   LOCKED     a complete L/R pair has been seen since the last resync
//   SYNC_ERR   sticky framing error
//   OVERRUN    sticky dropped-pair error
module i2s_rx_sequencer #(
  parameter int DW   = 24,
  parameter int SLOT = 32
) (
  input  logic          MCLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          SDATA,
  input  logic          BCLK_RISE,
  input  logic          LR_RISE,
  input  logic          LR_FALL,
  input  logic          READY,
  input  logic          ERR_CLR,
  output logic [DW-1:0] L_DATA,
  output logic [DW-1:0] R_DATA,
  output logic          VALID,
  output logic          LOCKED,
  output logic          SYNC_ERR,
  output logic          OVERRUN
);

  localparam int BCW     = (DW > 2) ? $clog2(DW) : 1;
  localparam int SCW_MIN = $clog2(SLOT + 1);
  localparam int SCW     = (SCW_MIN > 6) ? SCW_MIN : 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHIFT,
    S_PAD
  } state_t;

  state_t          r_state;
  logic            r_ch;        // 0 = left slot, 1 = right slot
  logic [BCW-1:0]  r_bit_cnt;
  logic [SCW-1:0]  r_slot_cnt;
  logic [DW-2:0]   r_shift;     // the final bit is taken straight from SDATA
  logic [DW-1:0]   r_word_l;
  logic [DW-1:0]   r_word_r;
  logic [DW-1:0]   r_l_data;
  logic [DW-1:0]   r_r_data;
  logic            r_valid;
  logic            r_locked;
  logic            r_sync_err;
  logic            r_overrun;
  logic            r_pair_vld_p1; // pair completed last cycle, awaiting handoff

  logic [DW-1:0]   w_word;
  logic            w_last_bit;
  logic            w_slot_ovf;
  logic            w_load;
  logic            w_drop;
  logic            w_short;
  logic            w_sync_set;

  assign w_word     = {r_shift, SDATA};
  assign w_last_bit = (r_bit_cnt == BCW'(DW - 1));
  // The counter holds the BCLKs already seen, so this strobe is number SLOT+1.
  assign w_slot_ovf = (r_slot_cnt == SCW'(SLOT));
  assign w_load     = r_pair_vld_p1 && (!r_valid || READY);
  assign w_drop     = r_pair_vld_p1 && r_valid && !READY;
  assign w_short    = (r_state == S_DELAY) || (r_state == S_SHIFT);

  // Framing error detection; LR strobes outrank a coincident BCLK strobe.
  always_comb begin
    w_sync_set = 1'b0;
    if (EN) begin
      if (LR_RISE && LR_FALL) begin
        w_sync_set = 1'b1;
      end else if (LR_FALL) begin
        w_sync_set = w_short || ((r_state == S_PAD) && !r_ch);
      end else if (LR_RISE) begin
        w_sync_set = w_short || ((r_state == S_PAD) && r_ch);
      end else if (BCLK_RISE && (r_state != S_IDLE)) begin
        w_sync_set = w_slot_ovf;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_ch          <= 1'b0;
      r_bit_cnt     <= '0;
      r_slot_cnt    <= '0;
      r_shift       <= '0;
      r_word_l      <= '0;
      r_word_r      <= '0;
      r_l_data      <= '0;
      r_r_data      <= '0;
      r_valid       <= 1'b0;
      r_locked      <= 1'b0;
      r_sync_err    <= 1'b0;
      r_overrun     <= 1'b0;
      r_pair_vld_p1 <= 1'b0;
    end else begin
      // Output handoff: a load in the same cycle as a consume keeps VALID high.
      if (w_load) begin
        r_l_data <= r_word_l;
        r_r_data <= r_word_r;
        r_valid  <= 1'b1;
      end else if (r_valid && READY) begin
        r_valid <= 1'b0;
      end
      r_pair_vld_p1 <= 1'b0;

      // Sticky flags: a set in the same cycle as ERR_CLR wins.
      r_sync_err <= w_sync_set | (r_sync_err & ~ERR_CLR);
      r_overrun  <= (w_drop & EN) | (r_overrun & ~ERR_CLR);

      if (!EN) begin
        r_state    <= S_IDLE;
        r_locked   <= 1'b0;
        r_bit_cnt  <= '0;
        r_slot_cnt <= '0;
      end else if (LR_RISE && LR_FALL) begin
        r_state    <= S_IDLE;
        r_ch       <= 1'b0;
        r_locked   <= 1'b0;
        r_bit_cnt  <= '0;
        r_slot_cnt <= '0;
        r_shift    <= '0;
        r_word_l   <= '0;
      end else if (LR_FALL) begin
        // Accepted or not, a falling LRCLK always starts a fresh left slot.
        r_state    <= S_DELAY;
        r_ch       <= 1'b0;
        r_bit_cnt  <= '0;
        r_slot_cnt <= '0;
        if (w_sync_set) begin
          r_locked <= 1'b0;
          r_shift  <= '0;
          r_word_l <= '0;
        end
      end else if (LR_RISE) begin
        if (w_sync_set) begin
          r_state    <= S_IDLE;
          r_ch       <= 1'b0;
          r_locked   <= 1'b0;
          r_bit_cnt  <= '0;
          r_slot_cnt <= '0;
          r_shift    <= '0;
          r_word_l   <= '0;
        end else if (r_state == S_PAD) begin
          r_state    <= S_DELAY;
          r_ch       <= 1'b1;
          r_bit_cnt  <= '0;
          r_slot_cnt <= '0;
        end
      end else if (BCLK_RISE && (r_state != S_IDLE)) begin
        if (w_slot_ovf) begin
          r_state    <= S_IDLE;
          r_ch       <= 1'b0;
          r_locked   <= 1'b0;
          r_bit_cnt  <= '0;
          r_slot_cnt <= '0;
          r_shift    <= '0;
          r_word_l   <= '0;
        end else begin
          r_slot_cnt <= r_slot_cnt + SCW'(1);
          case (r_state)
            S_DELAY: begin
              // First BCLK after the LR edge is the I2S one-bit delay.
              r_state   <= S_SHIFT;
              r_bit_cnt <= '0;
            end
            S_SHIFT: begin
              r_shift   <= w_word[DW-2:0];
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              if (w_last_bit) begin
                r_state <= S_PAD;
                if (r_ch) begin
                  r_word_r      <= w_word;
                  r_locked      <= 1'b1;
                  r_pair_vld_p1 <= 1'b1;
                end else begin
                  r_word_l <= w_word;
                end
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign L_DATA   = r_l_data;
  assign R_DATA   = r_r_data;
  assign VALID    = r_valid;
  assign LOCKED   = r_locked;
  assign SYNC_ERR = r_sync_err;
  assign OVERRUN  = r_overrun;

endmodule
